// File: rtl/jpeg_rgb_to_ycbcr.sv
// RGB888 -> level-shifted signed YCbCr (BT.601, Q8) with optional 4:2:2 / 4:2:0 chroma
// decimation. Two-stage pipeline (products, then sum/round/clamp/subsample) with valid/ready.
module jpeg_rgb_to_ycbcr #(
  parameter int IMG_WIDTH = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              frame_start,
  input  logic [1:0]        subsample_mode,
  input  logic [7:0]        r_in,
  input  logic [7:0]        g_in,
  input  logic [7:0]        b_in,
  output logic signed [8:0] y_out,
  output logic signed [8:0] cb_out,
  output logic signed [8:0] cr_out,
  output logic              chroma_valid,
  output logic              valid_out,
  input  logic              ready_in
);

  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {
    MODE_444 = 2'd0,
    MODE_422 = 2'd1,
    MODE_420 = 2'd2,
    MODE_RSV = 2'd3
  } mode_t;

  logic adv, accept;
  assign adv       = !valid_out | ready_in;
  assign ready_out = adv;
  assign accept    = valid_in & adv;

  // Column / row position; frame_start re-bases the pixel being accepted.
  logic [XW-1:0] x_cnt, x_cur;
  logic          row_odd, row_cur;

  always_comb begin
    x_cur   = frame_start ? '0 : x_cnt;
    row_cur = frame_start ? 1'b0 : row_odd;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_cnt   <= '0;
      row_odd <= 1'b0;
    end else if (accept) begin
      if (x_cur == X_LAST) begin
        x_cnt   <= '0;
        row_odd <= ~row_cur;
      end else begin
        x_cnt   <= x_cur + 1'b1;
        row_odd <= row_cur;
      end
    end
  end

  // Stage 1: product registers and per-pixel position tags.
  logic        s1_valid, s1_odd, s1_last, s1_row;
  mode_t       s1_mode;
  logic [15:0] p_yr, p_yg, p_yb, p_cbr, p_cbg, p_cbb, p_crr, p_crg, p_crb;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_odd   <= 1'b0;
      s1_last  <= 1'b0;
      s1_row   <= 1'b0;
      s1_mode  <= MODE_444;
      p_yr  <= '0; p_yg  <= '0; p_yb  <= '0;
      p_cbr <= '0; p_cbg <= '0; p_cbb <= '0;
      p_crr <= '0; p_crg <= '0; p_crb <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_odd  <= x_cur[0];
        s1_last <= (x_cur == X_LAST);
        s1_row  <= row_cur;
        s1_mode <= mode_t'(subsample_mode);
        p_yr  <= 16'(r_in) * 16'd77;
        p_yg  <= 16'(g_in) * 16'd150;
        p_yb  <= 16'(b_in) * 16'd29;
        p_cbr <= 16'(r_in) * 16'd43;
        p_cbg <= 16'(g_in) * 16'd85;
        p_cbb <= 16'(b_in) * 16'd128;
        p_crr <= 16'(r_in) * 16'd128;
        p_crg <= 16'(g_in) * 16'd107;
        p_crb <= 16'(b_in) * 16'd21;
      end
    end
  end

  function automatic logic signed [8:0] clamp9(input logic signed [17:0] v);
    if (v > 18'sd127)       return 9'sd127;
    else if (v < -18'sd128) return -9'sd128;
    else                    return v[8:0];
  endfunction

  function automatic logic signed [8:0] avg9(input logic signed [8:0] a, input logic signed [8:0] b);
    logic signed [9:0] s;
    s = {a[8], a} + {b[8], b} + 10'sd1;
    return 9'(s >>> 1);
  endfunction

  // Stage 2 arithmetic: sums wrap modulo 2^18, giving two's-complement chroma.
  logic [17:0]        y_raw, cb_raw, cr_raw;
  logic signed [17:0] cb_sh, cr_sh;
  logic [7:0]         y_val;
  logic signed [8:0]  y9, cb_c, cr_c;

  always_comb begin
    y_raw  = 18'(p_yr) + 18'(p_yg) + 18'(p_yb) + 18'd128;
    cb_raw = 18'(p_cbb) + 18'd128 - 18'(p_cbr) - 18'(p_cbg);
    cr_raw = 18'(p_crr) + 18'd128 - 18'(p_crg) - 18'(p_crb);
    y_val  = 8'(y_raw >> 8);
    y9     = $signed({1'b0, y_val} - 9'd128);
    cb_sh  = $signed(cb_raw) >>> 8;
    cr_sh  = $signed(cr_raw) >>> 8;
    cb_c   = clamp9(cb_sh);
    cr_c   = clamp9(cr_sh);
  end

  logic signed [8:0] cb_even, cr_even;
  logic              row_ok;
  assign row_ok = !(s1_mode == MODE_420 && s1_row);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_out    <= 1'b0;
      chroma_valid <= 1'b0;
      y_out        <= '0;
      cb_out       <= '0;
      cr_out       <= '0;
      cb_even      <= '0;
      cr_even      <= '0;
    end else if (adv) begin
      valid_out    <= s1_valid;
      chroma_valid <= 1'b0;
      if (s1_valid) begin
        y_out <= y9;
        case (s1_mode)
          MODE_422, MODE_420: begin
            if (!s1_odd && !s1_last) begin
              cb_even <= cb_c;
              cr_even <= cr_c;
            end else if (s1_odd) begin
              cb_out       <= avg9(cb_even, cb_c);
              cr_out       <= avg9(cr_even, cr_c);
              chroma_valid <= row_ok;
            end else begin
              cb_out       <= cb_c;
              cr_out       <= cr_c;
              chroma_valid <= row_ok;
            end
          end
          default: begin
            cb_out       <= cb_c;
            cr_out       <= cr_c;
            chroma_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jpeg_rgb_to_ycbcr.sv
// Bench for jpeg_rgb_to_ycbcr (IMG_WIDTH=4): constant vector table, hand sequences for
// pairing, row decimation, backpressure and reset, and a scoreboard fed at acceptance.
module tb_jpeg_rgb_to_ycbcr;

  localparam int W = 4;

  logic              clk = 1'b0;
  logic              rst_n, valid_in, ready_out, frame_start, chroma_valid, valid_out, ready_in;
  logic [1:0]        subsample_mode;
  logic [7:0]        r_in, g_in, b_in;
  logic signed [8:0] y_out, cb_out, cr_out;

  always #5 clk = ~clk;

  jpeg_rgb_to_ycbcr #(.IMG_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
    .frame_start(frame_start), .subsample_mode(subsample_mode),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .y_out(y_out), .cb_out(cb_out), .cr_out(cr_out),
    .chroma_valid(chroma_valid), .valid_out(valid_out), .ready_in(ready_in)
  );

  typedef struct {
    logic signed [8:0] y, cb, cr;
    logic              cv;
  } exp_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic [1:0] mode;
    logic       fs;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference position / pair state, advanced once per accepted pixel.
  int mx = 0, mrow = 0, pcb = 0, pcr = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                 input logic [1:0] mode, input logic fs);
    exp_t e;
    int ri, gi, bi, yi, cb, cr, x, row, m;
    ri = int'(r); gi = int'(g); bi = int'(b);
    yi = (77 * ri + 150 * gi + 29 * bi + 128) >>> 8;
    cb = (-43 * ri - 85 * gi + 128 * bi + 128) >>> 8;
    cr = (128 * ri - 107 * gi - 21 * bi + 128) >>> 8;
    if (cb > 127) cb = 127;
    if (cb < -128) cb = -128;
    if (cr > 127) cr = 127;
    if (cr < -128) cr = -128;
    x   = fs ? 0 : mx;
    row = fs ? 0 : mrow;
    m   = (mode == 2'd3) ? 0 : int'(mode);
    e.cv = 1'b1;
    if (m != 0) begin
      if ((x % 2) == 0 && x != W - 1) begin
        pcb = cb; pcr = cr; e.cv = 1'b0;
      end else if ((x % 2) == 1) begin
        cb = (pcb + cb + 1) >>> 1;
        cr = (pcr + cr + 1) >>> 1;
      end
      if (m == 2 && row != 0) e.cv = 1'b0;
    end
    if (x == W - 1) begin
      mx = 0; mrow = (row == 0) ? 1 : 0;
    end else begin
      mx = x + 1; mrow = row;
    end
    e.y  = 9'(yi - 128);
    e.cb = 9'(cb);
    e.cr = 9'(cr);
    return e;
  endfunction

  task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic [1:0] mode, input logic fs, input logic use_tab, input exp_t te);
    exp_t e;
    int   n;
    n = 0;
    r_in = r; g_in = g; b_in = b; subsample_mode = mode; frame_start = fs; valid_in = 1'b1;
    @(negedge clk);
    while (!ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready_out) begin
      chk("accept_timeout", 0, 1);
      valid_in = 1'b0; frame_start = 1'b0;
      return;
    end
    e = model(r, g, b, mode, fs);
    if (use_tab) e = te;
    sb.push_back(e);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic drive_m(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [1:0] mode, input logic fs);
    exp_t z;
    z = '{default: '0};
    drive(r, g, b, mode, fs, 1'b0, z);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output monitor: a beat is consumed at the next rising edge when valid_out & ready_in.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chroma_valid && !valid_out) chk("cv_without_valid", 1, 0);
      if (valid_out && ready_in) begin
        if (sb.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("y_out", int'(y_out), int'(e.y));
          chk("chroma_valid", int'(chroma_valid), int'(e.cv));
          if (e.cv) begin
            chk("cb_out", int'(cb_out), int'(e.cb));
            chk("cr_out", int'(cr_out), int'(e.cr));
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[8];
    exp_t z;
    logic signed [8:0] hy, hcb;
    logic done;
    z = '{default: '0};
    tab[0] = '{255, 255, 255, 2'd0, 1'b1, '{9'sd127,   9'sd0,    9'sd0,    1'b1}};
    tab[1] = '{  0,   0, 255, 2'd0, 1'b0, '{-9'sd99,   9'sd127, -9'sd21,   1'b1}};
    tab[2] = '{255, 255,   0, 2'd0, 1'b0, '{9'sd98,   -9'sd127,  9'sd21,   1'b1}};
    tab[3] = '{  0,   0,   0, 2'd0, 1'b0, '{-9'sd128,  9'sd0,    9'sd0,    1'b1}};
    tab[4] = '{255,   0,   0, 2'd0, 1'b0, '{-9'sd51,  -9'sd43,   9'sd127,  1'b1}};
    tab[5] = '{  0, 255,   0, 2'd0, 1'b0, '{9'sd21,   -9'sd85,  -9'sd107,  1'b1}};
    tab[6] = '{128, 128, 128, 2'd3, 1'b0, '{9'sd0,     9'sd0,    9'sd0,    1'b1}};
    tab[7] = '{  0,   0, 255, 2'd3, 1'b0, '{-9'sd99,   9'sd127, -9'sd21,   1'b1}};

    rst_n = 1'b0; valid_in = 1'b0; frame_start = 1'b0; subsample_mode = 2'd0;
    r_in = '0; g_in = '0; b_in = '0; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_chroma_valid", int'(chroma_valid), 0);
    chk("rst_y_out", int'(y_out), 0);
    chk("rst_ready_out", int'(ready_out), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two-cycle latency on a single pixel.
    drive_m(8'd255, 8'd255, 8'd255, 2'd0, 1'b1);
    chk("lat_cycle1_valid", int'(valid_out), 0);
    @(posedge clk);
    #1;
    chk("lat_cycle2_valid", int'(valid_out), 1);
    chk("lat_cycle2_y", int'(y_out), 127);
    drain();

    // Constant vector table, streamed back to back.
    for (int i = 0; i < 8; i++)
      drive(tab[i].r, tab[i].g, tab[i].b, tab[i].mode, tab[i].fs, 1'b1, tab[i].e);
    drain();

    // 4:2:2 pairing with hand-derived expectations.
    drive(8'd0, 8'd0, 8'd255, 2'd1, 1'b1, 1'b1, '{-9'sd99, 9'sd0, 9'sd0, 1'b0});
    drive(8'd0, 8'd0, 8'd0,   2'd1, 1'b0, 1'b1, '{-9'sd128, 9'sd64, -9'sd10, 1'b1});
    drain();

    // 4:2:0 over two lines, then frame_start restarts the pattern.
    for (int i = 0; i < 8; i++)
      drive_m(8'($urandom), 8'($urandom), 8'($urandom), 2'd2, (i == 0) ? 1'b1 : 1'b0);
    drive_m(8'd10, 8'd200, 8'd30, 2'd2, 1'b1);
    drive_m(8'd250, 8'd5, 8'd90, 2'd2, 1'b0);
    drain();

    // Backpressure: stall 5+ cycles with input pending.
    ready_in = 1'b0;
    fork
      begin
        drive_m(8'd1, 8'd2, 8'd3, 2'd1, 1'b1);
        drive_m(8'd200, 8'd100, 8'd50, 2'd1, 1'b0);
        drive_m(8'd7, 8'd250, 8'd9, 2'd1, 1'b0);
        drive_m(8'd90, 8'd0, 8'd255, 2'd1, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        hy = y_out;
        hcb = cb_out;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("stall_ready_out", int'(ready_out), 0);
          chk("stall_valid_out", int'(valid_out), 1);
          chk("stall_y_hold", int'(y_out), int'(hy));
          chk("stall_cb_hold", int'(cb_out), int'(hcb));
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
      end
    join
    drain();

    // Random pixels with random downstream stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          drive_m(8'($urandom), 8'($urandom), 8'($urandom), (i < 12) ? 2'd0 : 2'd1,
                  (i == 0 || i == 12) ? 1'b1 : 1'b0);
          if ($urandom_range(0, 3) == 0) @(posedge clk);
          #0;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          ready_in = ($urandom_range(0, 2) != 0);
        end
        ready_in = 1'b1;
      end
    join
    drain();

    // Mid-stream reset drops in-flight pixels and restarts the column count.
    drive_m(8'd50, 8'd60, 8'd70, 2'd1, 1'b1);
    drive_m(8'd80, 8'd90, 8'd100, 2'd1, 1'b0);
    chk("pre_rst_valid_out", int'(valid_out), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid_out", int'(valid_out), 0);
    chk("mid_rst_chroma_valid", int'(chroma_valid), 0);
    chk("mid_rst_y_out", int'(y_out), 0);
    chk("mid_rst_cb_out", int'(cb_out), 0);
    chk("mid_rst_cr_out", int'(cr_out), 0);
    sb.delete();
    mx = 0; mrow = 0; pcb = 0; pcr = 0;
    rst_n = 1'b1;
    drive_m(8'd0, 8'd0, 8'd255, 2'd1, 1'b0);
    drive_m(8'd30, 8'd40, 8'd50, 2'd1, 1'b0);
    drive_m(8'd255, 8'd0, 8'd128, 2'd1, 1'b0);
    drive_m(8'd12, 8'd34, 8'd56, 2'd1, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
